// File: rtl/data_memory_responder_if.sv
// Cache-to-memory port: word read/write request from the cache, completion
// strobe, read data and status from the memory responder.
interface data_memory_responder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ready;
    logic                  done;
    logic                  err;

    modport master (
        output rd_en, wr_en, address, wr_data,
        input  rd_data, ready, done, err
    );

    modport slave (
        input  rd_en, wr_en, address, wr_data,
        output rd_data, ready, done, err
    );
endinterface

// File: rtl/data_memory_responder.sv
// Main-memory responder for the cache: word reads/writes completed after a
// programmable latency, with abort on request drop and illegal-request flagging.
module data_memory_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned WR_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    data_memory_responder_if.slave   bus
);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      count, count_nxt;
    logic [DEPTH_LOG2-1:0] idx, idx_nxt;
    logic [DATA_WIDTH-1:0] wdata, wdata_nxt;
    logic                  ready_nxt;
    logic                  done_nxt;
    logic                  err_nxt;
    logic                  rd_load;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  unused_addr_bits;

    // Word index; byte offset and bits above the array are don't-care.
    assign req_idx          = bus.address[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{bus.address[ADDR_WIDTH-1:DEPTH_LOG2+2], bus.address[1:0]};

    // Next-state, counter and completion decode.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        idx_nxt   = idx;
        wdata_nxt = wdata;
        ready_nxt = 1'b0;
        err_nxt   = 1'b0;
        rd_load   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rd_en && bus.wr_en) begin
                    err_nxt = 1'b1;
                end else if (bus.rd_en) begin
                    idx_nxt   = req_idx;
                    count_nxt = CNT_W'(RD_LATENCY - 1);
                    state_nxt = READ;
                end else if (bus.wr_en) begin
                    idx_nxt   = req_idx;
                    wdata_nxt = bus.wr_data;
                    count_nxt = CNT_W'(WR_LATENCY - 1);
                    state_nxt = WRITE;
                end
            end
            READ: begin
                if (!bus.rd_en) begin
                    state_nxt = IDLE;
                end else if (count == '0) begin
                    rd_load   = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = RECOVER;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            WRITE: begin
                if (!bus.wr_en) begin
                    state_nxt = IDLE;
                end else if (count == '0) begin
                    mem_we    = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = RECOVER;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        done_nxt = (state_nxt == IDLE);
    end

    // State and registered outputs; reset overrides any completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            idx         <= '0;
            wdata       <= '0;
            bus.rd_data <= '0;
            bus.ready   <= 1'b0;
            bus.done    <= 1'b1;
            bus.err     <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            idx       <= idx_nxt;
            wdata     <= wdata_nxt;
            bus.ready <= ready_nxt;
            bus.done  <= done_nxt;
            bus.err   <= err_nxt;
            if (rd_load) bus.rd_data <= mem[idx];
        end
    end

    // Storage is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[idx] <= wdata;
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: DUT a uses 4/4 latency, DUT b uses read 1 / write 7 latency.
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    data_memory_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
    data_memory_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();

    data_memory_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10),
        .RD_LATENCY(4), .WR_LATENCY(4)
    ) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    data_memory_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10),
        .RD_LATENCY(1), .WR_LATENCY(7)
    ) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic        rd_v   [2];
    logic        wr_v   [2];
    logic [31:0] addr_v [2];
    logic [31:0] wdat_v [2];
    logic [31:0] rdd    [2];
    logic        rdy    [2];
    logic        dn     [2];
    logic        er     [2];

    assign bus_a.rd_en   = rd_v[0];
    assign bus_a.wr_en   = wr_v[0];
    assign bus_a.address = addr_v[0];
    assign bus_a.wr_data = wdat_v[0];
    assign bus_b.rd_en   = rd_v[1];
    assign bus_b.wr_en   = wr_v[1];
    assign bus_b.address = addr_v[1];
    assign bus_b.wr_data = wdat_v[1];
    assign rdd[0] = bus_a.rd_data;
    assign rdy[0] = bus_a.ready;
    assign dn[0]  = bus_a.done;
    assign er[0]  = bus_a.err;
    assign rdd[1] = bus_b.rd_data;
    assign rdy[1] = bus_b.ready;
    assign dn[1]  = bus_b.done;
    assign er[1]  = bus_b.err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access, wait for IDLE, then measure edges from sample to ready.
    task automatic access(input int d, input string tag, input bit is_wr,
                          input logic [31:0] a, input logic [31:0] data,
                          input int lat, input logic [31:0] exp_rd);
        int guard;
        int measured;
        rd_v[d]   = !is_wr;
        wr_v[d]   = is_wr;
        addr_v[d] = a;
        wdat_v[d] = data;
        guard = 0;
        while (!dn[d] && guard < 4) begin
            tick();
            guard++;
        end
        measured = -1;
        for (int k = 0; k <= lat + 2; k++) begin
            tick();
            if (k == 0) chk({tag, "_done_busy"}, 32'(dn[d]), 32'd0);
            if (rdy[d]) begin
                measured = k;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(measured), 32'(lat));
        if (!is_wr) chk({tag, "_rd_data"}, rdd[d], exp_rd);
        chk({tag, "_done_recover"}, 32'(dn[d]), 32'd0);
        rd_v[d] = 1'b0;
        wr_v[d] = 1'b0;
    endtask

    task automatic after_op(input int d, input string tag);
        tick();
        chk({tag, "_ready_pulse"}, 32'(rdy[d]), 32'd0);
        chk({tag, "_done_idle"}, 32'(dn[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 2; i++) begin
            rd_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = '0; wdat_v[i] = '0;
        end
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_done", 32'(dn[0]), 32'd1);
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_err", 32'(er[0]), 32'd0);
        chk("rst_rd_data", rdd[0], 32'd0);

        access(0, "wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4, 32'd0);
        after_op(0, "wr10");
        access(0, "rd10", 1'b0, 32'h10, 32'd0, 4, 32'hDEADBEEF);
        after_op(0, "rd10");
        repeat (10) tick();
        chk("rd10_hold", rdd[0], 32'hDEADBEEF);

        access(0, "wr20", 1'b1, 32'h20, 32'h12345678, 4, 32'd0);
        after_op(0, "wr20");

        // Write abort after two sampled cycles
        wr_v[0] = 1'b1; addr_v[0] = 32'h20; wdat_v[0] = 32'hCAFEF00D;
        tick(); tick();
        chk("wabort_done_busy", 32'(dn[0]), 32'd0);
        wr_v[0] = 1'b0;
        seen = 1'b0;
        repeat (8) begin tick(); if (rdy[0]) seen = 1'b1; end
        chk("wabort_no_ready", 32'(seen), 32'd0);
        chk("wabort_done", 32'(dn[0]), 32'd1);
        access(0, "rd20", 1'b0, 32'h20, 32'd0, 4, 32'h12345678);
        after_op(0, "rd20");

        // Read abort at 0x10 must leave the last read data in place
        rd_v[0] = 1'b1; addr_v[0] = 32'h10;
        tick(); tick();
        rd_v[0] = 1'b0;
        seen = 1'b0;
        repeat (8) begin tick(); if (rdy[0]) seen = 1'b1; end
        chk("rabort_no_ready", 32'(seen), 32'd0);
        chk("rabort_rd_data", rdd[0], 32'h12345678);

        // Illegal simultaneous request
        rd_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 32'h10; wdat_v[0] = 32'h0;
        tick();
        chk("illegal_err", 32'(er[0]), 32'd1);
        chk("illegal_ready", 32'(rdy[0]), 32'd0);
        chk("illegal_done", 32'(dn[0]), 32'd1);
        rd_v[0] = 1'b0; wr_v[0] = 1'b0;
        tick();
        chk("illegal_err_clear", 32'(er[0]), 32'd0);
        access(0, "rd10b", 1'b0, 32'h10, 32'd0, 4, 32'hDEADBEEF);
        after_op(0, "rd10b");

        // Reset in the middle of a write
        access(0, "wr80", 1'b1, 32'h80, 32'h0F0F0F0F, 4, 32'd0);
        after_op(0, "wr80");
        wr_v[0] = 1'b1; addr_v[0] = 32'h80; wdat_v[0] = 32'hA5A5A5A5;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("midrst_ready", 32'(rdy[0]), 32'd0);
        chk("midrst_done", 32'(dn[0]), 32'd1);
        chk("midrst_rd_data", rdd[0], 32'd0);
        reset = 1'b0; wr_v[0] = 1'b0;
        tick();
        chk("midrst_ready2", 32'(rdy[0]), 32'd0);
        access(0, "rd80", 1'b0, 32'h80, 32'd0, 4, 32'h0F0F0F0F);
        after_op(0, "rd80");

        // Reset coinciding with the completing edge
        wr_v[0] = 1'b1; addr_v[0] = 32'h80; wdat_v[0] = 32'h77777777;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("cmprst_ready", 32'(rdy[0]), 32'd0);
        reset = 1'b0; wr_v[0] = 1'b0;
        tick();
        access(0, "rd80b", 1'b0, 32'h80, 32'd0, 4, 32'h0F0F0F0F);
        after_op(0, "rd80b");

        // Write-back then fill through an aliased address on the 1/7 instance
        chk("b_rst_rd_data", rdd[1], 32'd0);
        chk("b_rst_done", 32'(dn[1]), 32'd1);
        access(1, "b_wr40", 1'b1, 32'h40, 32'h11111111, 7, 32'd0);
        access(1, "b_rd1040", 1'b0, 32'h1040, 32'd0, 1, 32'h11111111);
        after_op(1, "b_rd1040");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Memory-side responder for the cache controller's main-memory port. It answers word reads and writes (line fills and write-backs) after a programmable latency.
- Returns read data and a one-cycle `ready` strobe, which releases the cache stall.
- Replaces the fixed-delay memory model. It adds independent read/write latency, abort on request drop, and protocol error flagging.

Parameters:
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, byte address width
- DEPTH_LOG2, 10, log2 of word count (1024 words)
- RD_LATENCY, 4, cycles from read request sample to ready (>=1)
- WR_LATENCY, 4, cycles from write request sample to ready (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rd_en  input  1  read request, held high by cache until ready
- wr_en  input  1  write request, held high by cache until ready
- address  input  ADDR_WIDTH  byte address; word index = address[DEPTH_LOG2+1:2]
- wr_data  input  DATA_WIDTH  write data, held stable with wr_en
- rd_data  output  DATA_WIDTH  read data, valid in ready cycle of a read, held until next read completes
- ready  output  1  one-cycle completion strobe
- done  output  1  high when in IDLE and able to accept a request
- err  output  1  one-cycle pulse on illegal request (rd_en and wr_en both high in IDLE)

Behaviour:
- Reset: state=IDLE; rd_data=0, ready=0, done=1 (registered, effective the cycle after reset), err=0, counter=0.
- Memory array is not cleared by reset; contents survive reset.
- All outputs are registered.
- States: IDLE, READ, WRITE, RECOVER.
- IDLE transitions:
  - rd_en=1, wr_en=0: capture word index, counter=RD_LATENCY-1, go to READ.
  - wr_en=1, rd_en=0: capture index and wr_data, counter=WR_LATENCY-1, go to WRITE.
  - rd_en=wr_en=1: err=1 for one cycle, stay in IDLE, no access.
  - Neither asserted: stay in IDLE.
- READ/WRITE: counter decrements each cycle.
  - When counter==0 and the request is still high, complete the access and go to RECOVER.
  - Read completion: rd_data <= mem[idx], ready=1 in the same registered update.
  - Write completion: mem[idx] <= captured wr_data, ready=1.
  - RD_LATENCY=1 and WR_LATENCY=1 are legal: completion happens on the edge after the sample.
- Latency: request first sampled at edge E0; ready is high in the cycle following edge E0+LAT, i.e. LAT cycles after the request cycle.
- Abort: if the active request (rd_en in READ, wr_en in WRITE) is low at any sampled edge before completion:
  - return to IDLE;
  - no ready; no memory write; rd_data unchanged.
- Address and wr_data changes after capture are ignored.
- RECOVER: exactly one cycle, all requests ignored, ready=0, then IDLE.
  - The cache drops or switches its request during this cycle, so back-to-back write-back then fill costs LAT+2 cycles per access.
- done is high only in IDLE and low from the cycle after acceptance through RECOVER.
- Upper address bits above DEPTH_LOG2+1 and address[1:0] are ignored. Addresses wrap modulo 2^DEPTH_LOG2 words.
- Simultaneous reset and completion: reset wins; no write, no ready.
- Reset mid-operation: abort in-flight access and go to IDLE next cycle.

Test Plan:
- Reset, then write: reset high 2 cycles then low; wr_en=1, address=0x10, wr_data=0xDEADBEEF held until ready -> ready high exactly 4 cycles after request cycle, done low during op, one RECOVER cycle then done=1.
- Read-back: rd_en=1, address=0x10 held -> ready after 4 cycles with rd_data=0xDEADBEEF; rd_data still 0xDEADBEEF 10 cycles later.
- Abort: rd_en=1 at 0x10 for 2 cycles then low -> no ready pulse, rd_data unchanged. Write abort at 0x20 then read 0x20 -> old contents returned.
- Illegal request: rd_en=wr_en=1 in IDLE -> err=1 for one cycle, no ready, state stays IDLE, memory unchanged.
- Latency sweep and write-back/fill sequence: RD_LATENCY=1 and WR_LATENCY=7, write 0x11111111 to 0x40 then immediately read 0x1040 (aliases 0x40 with DEPTH_LOG2=10) -> write ready 7 cycles after request, read ready 1 cycle after its request, read returns 0x11111111.
- Reset mid-op: assert reset in cycle 2 of a write to 0x80 with 0xA5A5A5A5 -> no ready, done=1 after reset; subsequent read of 0x80 returns prior value.
